// File: rtl/board_view_renderer.sv
// Purpose: maps each screen pixel to a toroidal board cell, fetches the packed
//          board word, extracts the cell bit and overlays a cursor outline.
// Latency: 3 cycles from hcount/vcount/syncs in to pix_out/syncs out.
// Backpressure: none. One read address per cycle, so memory must accept back-to-back reads.
//
// Ports:
//   clk_in, rst_n_in              pixel clock, async active-low reset
//   hcount_in, vcount_in          timing-generator position
//   hsync_in, vsync_in, blank_in  timing-generator syncs (active low) and blank
//   view_x/y_in, cursor_x/y_in    view origin and cursor cell, latched on vsync fall
//   addr_r_out, data_r_in         board memory read port (data 1 cycle after address)
//   pix_out, hsync_out, vsync_out RGB444 pixel plus aligned syncs
//   frame_done_out                one-cycle pulse when view/cursor are latched
// Build option: define RENDERER_GRID_EN to draw grid lines on dead in-view cells.

module board_view_renderer #(
  parameter int          WORD_SIZE      = 16,
  parameter int          LOG_BOARD_SIZE = 8,
  parameter int          LOG_CELL_PIX   = 4,
  parameter int          VIEW_W         = 64,
  parameter int          VIEW_H         = 48,
  parameter int          LOG_MAX_ADDR   = 12,
  parameter logic [11:0] ALIVE_COLOR    = 12'hFFF,
  parameter logic [11:0] DEAD_COLOR     = 12'h000,
  parameter logic [11:0] CURSOR_COLOR   = 12'hF00,
  parameter logic [11:0] GRID_COLOR     = 12'h333
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      blank_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] view_y_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  output logic [LOG_MAX_ADDR-1:0]   addr_r_out,
  input  logic [WORD_SIZE-1:0]      data_r_in,
  output logic [11:0]               pix_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      frame_done_out
);

  localparam int LB        = LOG_BOARD_SIZE;
  localparam int LOG_WS    = $clog2(WORD_SIZE);
  localparam int BIT_W     = (LOG_WS > 0) ? LOG_WS : 1;
  // Words per board row is 2^ROW_SHIFT, so the row term of the address is a shift.
  localparam int ROW_SHIFT = LB - LOG_WS;
  localparam logic [11:0] H_LIM = 12'(VIEW_W << LOG_CELL_PIX);
  localparam logic [10:0] V_LIM = 11'(VIEW_H << LOG_CELL_PIX);
`ifdef RENDERER_GRID_EN
  localparam bit GRID_EN = 1'b1;
`else
  localparam bit GRID_EN = 1'b0;
`endif

  // Frame latch: view and cursor only change on the vsync falling edge so a
  // frame is always drawn from one consistent set of coordinates.
  logic          vsync_q;
  logic          vsync_fall;
  logic [LB-1:0] sh_view_x, sh_view_y, sh_cur_x, sh_cur_y;

  assign vsync_fall = !vsync_in && vsync_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vsync_q        <= 1'b1;
      frame_done_out <= 1'b0;
      sh_view_x      <= '0;
      sh_view_y      <= '0;
      sh_cur_x       <= '0;
      sh_cur_y       <= '0;
    end else begin
      vsync_q        <= vsync_in;
      frame_done_out <= vsync_fall;
      if (vsync_fall) begin
        sh_view_x <= view_x_in;
        sh_view_y <= view_y_in;
        sh_cur_x  <= cursor_x_in;
        sh_cur_y  <= cursor_y_in;
      end
    end
  end

  // Stage 0: screen position -> board cell (wraps naturally at LB bits).
  logic [LB-1:0]           cx, cy;
  logic [LOG_CELL_PIX-1:0] ox, oy;
  logic                    in_view, cur_edge, grid_px;
  logic [LOG_MAX_ADDR-1:0] addr_c;

  always_comb begin
    cx       = LB'(hcount_in >> LOG_CELL_PIX) + sh_view_x;
    cy       = LB'(vcount_in >> LOG_CELL_PIX) + sh_view_y;
    ox       = LOG_CELL_PIX'(hcount_in);
    oy       = LOG_CELL_PIX'(vcount_in);
    in_view  = ({1'b0, hcount_in} < H_LIM) && ({1'b0, vcount_in} < V_LIM);
    // Outline only: outermost pixel ring of the cursor cell.
    cur_edge = (cx == sh_cur_x) && (cy == sh_cur_y) &&
               ((ox == '0) || (ox == '1) || (oy == '0) || (oy == '1));
    grid_px  = (ox == '0) || (oy == '0);
    addr_c   = (LOG_MAX_ADDR'(cy) << ROW_SHIFT) | LOG_MAX_ADDR'(cx >> LOG_WS);
  end

  logic             s0_show, s0_cur_edge, s0_grid;
  logic [BIT_W-1:0] s0_bit;
  logic             s1_show, s1_cur_edge, s1_grid;
  logic [BIT_W-1:0] s1_bit;
  logic [1:0]       hs_d, vs_d;
  logic [11:0]      pix_c;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_r_out  <= '0;
      s0_show     <= 1'b0;
      s0_cur_edge <= 1'b0;
      s0_grid     <= 1'b0;
      s0_bit      <= '0;
      s1_show     <= 1'b0;
      s1_cur_edge <= 1'b0;
      s1_grid     <= 1'b0;
      s1_bit      <= '0;
      hs_d        <= 2'b11;
      vs_d        <= 2'b11;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      pix_out     <= 12'h000;
    end else begin
      // Stage 0
      addr_r_out  <= addr_c;
      s0_show     <= !blank_in && in_view;
      s0_cur_edge <= cur_edge;
      s0_grid     <= grid_px;
      s0_bit      <= BIT_W'(cx);
      // Stage 1: memory is busy with addr_r_out, sideband just waits.
      s1_show     <= s0_show;
      s1_cur_edge <= s0_cur_edge;
      s1_grid     <= s0_grid;
      s1_bit      <= s0_bit;
      // Stage 2
      pix_out     <= pix_c;
      hs_d        <= {hs_d[0], hsync_in};
      vs_d        <= {vs_d[0], vsync_in};
      hsync_out   <= hs_d[1];
      vsync_out   <= vs_d[1];
    end
  end

  // Stage 2 colour priority: blank/out-of-view, cursor outline, alive, grid, dead.
  always_comb begin
    pix_c = DEAD_COLOR;
    if (!s1_show)                pix_c = 12'h000;
    else if (s1_cur_edge)        pix_c = CURSOR_COLOR;
    else if (data_r_in[s1_bit])  pix_c = ALIVE_COLOR;
    else if (GRID_EN && s1_grid) pix_c = GRID_COLOR;
  end

endmodule

// File: tb/tb_board_view_renderer.sv
module tb_board_view_renderer;

`ifdef RENDERER_GRID_EN
  localparam logic [11:0] EDGE_DEAD = 12'h333;
  localparam bit          GRID_ON   = 1'b1;
`else
  localparam logic [11:0] EDGE_DEAD = 12'h000;
  localparam bit          GRID_ON   = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
  logic [7:0]  view_x_in = '0, view_y_in = '0, cursor_x_in = '0, cursor_y_in = '0;
  logic [11:0] addr_r_out;
  logic [15:0] data_r_in = '0;
  logic [11:0] pix_out;
  logic        hsync_out, vsync_out, frame_done_out;

  always #5 clk_in = ~clk_in;

  board_view_renderer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .view_x_in(view_x_in), .view_y_in(view_y_in),
    .cursor_x_in(cursor_x_in), .cursor_y_in(cursor_y_in),
    .addr_r_out(addr_r_out), .data_r_in(data_r_in),
    .pix_out(pix_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_done_out(frame_done_out)
  );

  // Board memory with a one-cycle synchronous read.
  logic [15:0] mem [0:4095];
  bit          board [0:255][0:255];   // [y][x], 1 = alive
  always @(posedge clk_in) data_r_in <= mem[addr_r_out];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cell(input int x, input int y);
    board[y][x] = 1'b1;
    mem[y*16 + x/16][x%16] = 1'b1;
  endtask

  // Model: colour of a screen pixel from the rendering rules.
  function automatic logic [11:0] model_pix(input int h, input int v, input logic bl,
                                            input int vx, input int vy, input int cx, input int cy);
    int bx, by;
    if (bl || h >= 64*16 || v >= 48*16) return 12'h000;
    bx = (h/16 + vx) % 256;
    by = (v/16 + vy) % 256;
    if (bx == cx && by == cy && (h%16 == 0 || h%16 == 15 || v%16 == 0 || v%16 == 15))
      return 12'hF00;
    if (board[by][bx]) return 12'hFFF;
    if (GRID_ON && (h%16 == 0 || v%16 == 0)) return 12'h333;
    return 12'h000;
  endfunction

  function automatic logic [11:0] model_addr(input int h, input int v, input int vx, input int vy);
    int bx, by;
    bx = (h/16 + vx) % 256;
    by = (v/16 + vy) % 256;
    return 12'(by*16 + bx/16);
  endfunction

  typedef struct {logic [11:0] pix; logic hs; logic vs;} exp_t;
  exp_t        exp_q[$];
  exp_t        m_e, c_e;
  int          m_vx = 0, m_vy = 0, m_cx = 0, m_cy = 0;
  logic        m_prev_vs = 1'b1;
  logic [11:0] exp_addr = '0;
  logic        exp_fd = 1'b0;
  bit          seen_edge = 1'b0;

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      exp_q.delete();
      exp_q.push_back('{pix: 12'h000, hs: 1'b1, vs: 1'b1});
      exp_q.push_back('{pix: 12'h000, hs: 1'b1, vs: 1'b1});
      m_vx = 0; m_vy = 0; m_cx = 0; m_cy = 0;
      m_prev_vs = 1'b1; exp_addr = '0; exp_fd = 1'b0; seen_edge = 1'b0;
    end else begin
      m_e.pix = model_pix(int'(hcount_in), int'(vcount_in), blank_in, m_vx, m_vy, m_cx, m_cy);
      m_e.hs  = hsync_in;
      m_e.vs  = vsync_in;
      exp_q.push_back(m_e);
      exp_addr = model_addr(int'(hcount_in), int'(vcount_in), m_vx, m_vy);
      exp_fd   = !vsync_in && m_prev_vs;
      if (exp_fd) begin
        m_vx = int'(view_x_in); m_vy = int'(view_y_in);
        m_cx = int'(cursor_x_in); m_cy = int'(cursor_y_in);
      end
      m_prev_vs = vsync_in;
      seen_edge = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (!rst_n_in || !seen_edge) begin
      chk("rst_pix", 32'(pix_out), 32'h0);
      chk("rst_hsync", 32'(hsync_out), 32'h1);
      chk("rst_vsync", 32'(vsync_out), 32'h1);
      chk("rst_addr", 32'(addr_r_out), 32'h0);
      chk("rst_frame_done", 32'(frame_done_out), 32'h0);
    end else if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL model_queue: got empty expected entry at %0t", $time);
    end else begin
      c_e = exp_q.pop_front();
      chk("pix", 32'(pix_out), 32'(c_e.pix));
      chk("hsync", 32'(hsync_out), 32'(c_e.hs));
      chk("vsync", 32'(vsync_out), 32'(c_e.vs));
      chk("addr", 32'(addr_r_out), 32'(exp_addr));
      chk("frame_done", 32'(frame_done_out), 32'(exp_fd));
    end
  end

  task automatic drive(input int h, input int v, input logic bl, input logic hs, input logic vs);
    hcount_in = 11'(h); vcount_in = 10'(v);
    blank_in = bl; hsync_in = hs; vsync_in = vs;
    @(posedge clk_in); #1;
  endtask

  task automatic px(input int h, input int v);
    drive(h, v, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic px_expect(input int h, input int v, input logic [11:0] want, input string name);
    px(h, v);
    drive(h, v, 1'b1, 1'b1, 1'b1);
    drive(h, v, 1'b1, 1'b1, 1'b1);
    chk(name, 32'(pix_out), 32'(want));
  endtask

  task automatic latch_frame(input string tag);
    drive(1100, 770, 1'b1, 1'b1, 1'b1);
    drive(1100, 770, 1'b1, 1'b1, 1'b0);
    chk({tag, "_pulse"}, 32'(frame_done_out), 32'h1);
    drive(1100, 770, 1'b1, 1'b1, 1'b0);
    chk({tag, "_one_cycle"}, 32'(frame_done_out), 32'h0);
    drive(1100, 770, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    set_cell(0, 0);
    set_cell(2, 1);
    set_cell(63, 0);
    set_cell(7, 2);
    // Model pins: packing of the board into memory words.
    chk("mem_word0", 32'(mem[0]), 32'h0001);
    chk("mem_word16", 32'(mem[16]), 32'h0004);

    view_x_in = 8'd7; view_y_in = 8'd7; cursor_x_in = 8'd2; cursor_y_in = 8'd1;
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst0_pix", 32'(pix_out), 32'h0);
    chk("arst0_hsync", 32'(hsync_out), 32'h1);
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;

    // First three outputs after release stay blank with syncs high.
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_1_pix", 32'(pix_out), 32'h0);
    chk("post_rst_1_hs", 32'(hsync_out), 32'h1);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_2_pix", 32'(pix_out), 32'h0);
    chk("post_rst_2_hs", 32'(hsync_out), 32'h1);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    // Shadows still (0,0): cursor outline at cell (0,0), view inputs ignored.
    chk("prelatch_cursor", 32'(pix_out), 32'hF00);
    chk("post_rst_3_hs", 32'(hsync_out), 32'h0);

    view_x_in = 8'd0; view_y_in = 8'd0;
    latch_frame("latch1");

    // Latency: address at t+1, pixel at t+3.
    px(0, 0);
    chk("lat_addr", 32'(addr_r_out), 32'h0);
    px(16, 0);
    px(32, 0);
    chk("lat_pix_t3", 32'(pix_out), 32'hFFF);
    px(48, 0);
    chk("lat_h16", 32'(pix_out), 32'(EDGE_DEAD));

    // Cursor at (2,1).
    px_expect(32, 16, 12'hF00, "cur_top_left");
    px_expect(47, 31, 12'hF00, "cur_bot_right");
    px_expect(40, 24, 12'hFFF, "cur_inside");
    px_expect(48, 16, EDGE_DEAD, "cur_next_cell");
    px(40, 24);
    chk("addr_cell_2_1", 32'(addr_r_out), 32'd16);
    px(600, 300);
    chk("addr_600_300", 32'(addr_r_out), 32'd290);

    // Mid-frame changes must not show until the next latch.
    view_x_in = 8'd5; cursor_x_in = 8'd5; cursor_y_in = 8'd0;
    px_expect(8, 8, 12'hFFF, "midframe_view");
    px_expect(80, 0, EDGE_DEAD, "midframe_cursor");
    latch_frame("latch2");
    px_expect(0, 0, 12'hF00, "shift_cursor");
    px_expect(8, 8, 12'h000, "shift_view");
    px_expect(936, 0, 12'hFFF, "shift_alive");

    // Wrap-around view origin; cursor beyond the visible window.
    view_x_in = 8'd255; view_y_in = 8'd0; cursor_x_in = 8'd63; cursor_y_in = 8'd0;
    latch_frame("latch3");
    px(16, 0);
    chk("wrap_addr", 32'(addr_r_out), 32'h0);
    drive(16, 0, 1'b1, 1'b1, 1'b1);
    drive(16, 0, 1'b1, 1'b1, 1'b1);
    chk("wrap_h16", 32'(pix_out), 32'hFFF);
    px_expect(31, 0, 12'hFFF, "wrap_h31");
    px_expect(0, 0, EDGE_DEAD, "wrap_dead_h0");
    px_expect(1024, 0, 12'h000, "cur_outside_view");
    drive(16, 0, 1'b1, 1'b1, 1'b1);
    drive(16, 0, 1'b1, 1'b1, 1'b1);
    drive(16, 0, 1'b1, 1'b1, 1'b1);
    chk("blank_in_view", 32'(pix_out), 32'h000);

    // Mixed traffic with occasional latches, checked by the model every cycle.
    for (int i = 0; i < 400; i++) begin
      view_x_in   = 8'($urandom_range(0, 255));
      view_y_in   = 8'($urandom_range(0, 255));
      cursor_x_in = 8'($urandom_range(0, 70));
      cursor_y_in = 8'($urandom_range(0, 50));
      drive($urandom_range(0, 1300), $urandom_range(0, 800),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) != 0));
    end

    // Asynchronous reset in the middle of a line.
    drive(500, 100, 1'b0, 1'b0, 1'b1);
    drive(500, 100, 1'b0, 1'b0, 1'b1);
    drive(500, 100, 1'b0, 1'b0, 1'b1);
    chk("pre_arst_hs", 32'(hsync_out), 32'h0);
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_pix", 32'(pix_out), 32'h0);
    chk("arst_hsync", 32'(hsync_out), 32'h1);
    chk("arst_vsync", 32'(vsync_out), 32'h1);
    chk("arst_addr", 32'(addr_r_out), 32'h0);
    @(posedge clk_in);
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    chk("post_arst_1_pix", 32'(pix_out), 32'h0);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    chk("post_arst_2_pix", 32'(pix_out), 32'h0);
    chk("post_arst_2_hs", 32'(hsync_out), 32'h1);
    drive(0, 0, 1'b0, 1'b0, 1'b1);
    chk("post_arst_shadow_zero", 32'(pix_out), 32'hF00);
    drive(0, 0, 1'b1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_view_renderer.md
# board_view_renderer

- Parametrised pixel pipeline between the XVGA timing generator and the VGA pins.
- Maps each screen pixel to a board cell, reads the packed board word from board memory, extracts the cell bit, and overlays a cursor outline.
- Emits a colour plus delayed sync signals at a fixed latency.
- Replaces the fixed-size render/cursor path; board wraps toroidally, so any view origin is legal.

## Interface
- WORD_SIZE, 16, cells packed per memory word (power of two)
- LOG_BOARD_SIZE, 8, board is 2^LOG_BOARD_SIZE cells square
- LOG_CELL_PIX, 4, each cell drawn as 2^LOG_CELL_PIX square pixels
- VIEW_W, 64, cells shown horizontally
- VIEW_H, 48, cells shown vertically
- LOG_MAX_ADDR, 12, memory address width (≥ 2·LOG_BOARD_SIZE − log2 WORD_SIZE)
- ALIVE_COLOR, 12'hFFF; DEAD_COLOR, 12'h000; CURSOR_COLOR, 12'hF00; GRID_COLOR, 12'h333

Ports:
- clk_in  in  1  pixel clock
- rst_n_in  in  1  asynchronous, active-low reset
- hcount_in  in  11  timing-generator pixel column
- vcount_in  in  10  timing-generator line
- hsync_in, vsync_in  in  1 each  active-low syncs from the timing generator
- blank_in  in  1  high outside the active area
- view_x_in, view_y_in  in  LOG_BOARD_SIZE  board cell shown at the top-left of the view
- cursor_x_in, cursor_y_in  in  LOG_BOARD_SIZE  cursor board cell
- addr_r_out  out  LOG_MAX_ADDR  board memory read address
- data_r_in  in  WORD_SIZE  read data, valid exactly 1 cycle after address
- pix_out  out  12  RGB444 pixel
- hsync_out, vsync_out  out  1 each  syncs delayed to align with pix_out
- frame_done_out  out  1  one-cycle pulse when new view/cursor values are latched

## Operation
- **Frame latch:** on the cycle vsync_in is 0 and its registered copy is 1 (falling edge):
  - latch view_x/view_y/cursor_x/cursor_y into shadow registers;
  - pulse frame_done_out.
- All rendering uses the shadow registers only; no mid-frame tearing.
- **Stage 0** (registered):
  - cx = (hcount_in >> LOG_CELL_PIX) + view_x, modulo 2^LOG_BOARD_SIZE; cy likewise from vcount_in and view_y.
  - addr_r_out = cy·(2^LOG_BOARD_SIZE / WORD_SIZE) + cx / WORD_SIZE.
  - Carry forward: bit index = cx mod WORD_SIZE; pixel offsets ox/oy = low LOG_CELL_PIX bits of hcount/vcount; in_view = (hcount_in < VIEW_W<<LOG_CELL_PIX) && (vcount_in < VIEW_H<<LOG_CELL_PIX); cursor_hit = (cx==cursor_x && cy==cursor_y); blank.
- **Stage 1:** memory access cycle; sideband delayed one cycle.
- **Stage 2** (registered into pix_out). Priority:
  1. blank or !in_view → 12'h000;
  2. cursor_hit and (ox∈{0, 2^LOG_CELL_PIX−1} or oy∈{0, 2^LOG_CELL_PIX−1}) → CURSOR_COLOR;
  3. data_r_in[bit] → ALIVE_COLOR;
  4. grid (see Configuration);
  5. DEAD_COLOR.
- Sync outputs pass through the same 3-stage delay line.

## Timing
- Latency: pixel for hcount_in at cycle t appears on pix_out at t+3; hsync_out/vsync_out equal hsync_in/vsync_in from t−3.
- One address issued per cycle, no stalls; memory must accept back-to-back reads.
- Reset (rst_n_in low, any time, asynchronous): pix_out=0, addr_r_out=0, hsync_out=1, vsync_out=1, frame_done_out=0, shadow registers=0, pipeline flushed to blank.
- After reset release: the first 3 output cycles are blank and syncs are high.
- Until the first vsync falling edge, rendering uses the view origin and cursor at (0,0).
- Wrap-around: with view_x = 2^LOG_BOARD_SIZE−1, screen cell 1 maps to board column 0.
- Edge cases:
  - cursor outside the view → never drawn;
  - cursor inputs changing mid-frame → ignored until the next latch;
  - simultaneous vsync edge and reset → reset wins.

## Configuration
- **RENDERER_GRID_EN defined:** dead in-view pixels with ox==0 or oy==0 show GRID_COLOR. Alive and cursor pixels take precedence.
- **Undefined:** no grid logic; dead pixels are DEAD_COLOR.

## Test plan
- **Reset mid-frame:** drive rst_n_in low at hcount=500 → pix_out=0 and syncs=1 immediately; outputs stay blank for 3 cycles after release.
- **Latency:** memory word 0 = 16'h0001, view (0,0), hcount=0, vcount=0 → addr_r_out=0 at t+1; pix_out=12'hFFF at t+3; hcount=16 gives 12'h000.
- **Wrap:** view_x=255, view_y=0, board cell (0,0) alive → pixels hcount 16–31 of line 0 are 12'hFFF; the address at hcount=16 is 0.
- **Cursor:** cursor (2,1), view (0,0):
  - (hcount 32, vcount 16) and (47, 31) → 12'hF00;
  - (40, 24) → cell colour.
- **Frame latch:** change view_x from 0 to 5 mid-frame → unchanged until the vsync falling edge, which pulses frame_done_out for exactly 1 cycle; the next frame is shifted 5 cells.
- **Grid (RENDERER_GRID_EN):** dead cell at hcount=0 → 12'h333; alive cell at hcount=0 → 12'hFFF. Without the macro → 12'h000.
